steer_en: RTL and testbench

STEER_EN -- requirements
Module: steer_en

---
 rtl/steer_en.sv | 110 +++++++++++
 tb/tb_steer_en.sv | 117 +++++++++++
 2 files changed

// File: rtl/steer_en.sv
// Rider-presence / balance gate for the steering path: decides from the two
// load cells whether a rider is on board and settled long enough to steer.
module steer_en #(
    parameter int          FAST_SIM      = 0,
    parameter logic [11:0] MIN_RIDER_WT  = 12'h200,
    parameter logic [11:0] WT_HYSTERESIS = 12'h040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        en_steer,
    output logic        rider_off
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        STEER_EN = 2'd2
    } state_t;

    localparam logic [12:0] WT_HI = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYSTERESIS};
    // Clamp the low threshold at zero so an oversized band cannot wrap.
    localparam logic [12:0] WT_LO = (MIN_RIDER_WT > WT_HYSTERESIS) ?
                                    ({1'b0, MIN_RIDER_WT} - {1'b0, WT_HYSTERESIS}) : 13'd0;

    state_t      state_q;
    logic [25:0] tmr_q;
    logic        en_steer_q;
    logic        rider_off_q;

    logic [12:0]        sum;
    logic signed [12:0] diff;
    logic [12:0]        abs_diff;
    logic [12:0]        sum_15_16;
    logic               sum_gt_min;
    logic               sum_lt_min;
    logic               diff_gt_1_4;
    logic               diff_gt_15_16;
    logic               tmr_full;

    assign sum       = {1'b0, lft_ld} + {1'b0, rght_ld};
    assign diff      = $signed({1'b0, lft_ld}) - $signed({1'b0, rght_ld});
    // Magnitude never exceeds 12'hFFF, so the top bit of abs_diff is always 0.
    assign abs_diff  = diff[12] ? 13'(-diff) : 13'(diff);
    assign sum_15_16 = sum - (sum >> 4);

    assign sum_gt_min    = sum > WT_HI;
    assign sum_lt_min    = sum < WT_LO;
    assign diff_gt_1_4   = abs_diff > (sum >> 2);
    assign diff_gt_15_16 = abs_diff > sum_15_16;

    assign tmr_full = (FAST_SIM != 0) ? (&tmr_q[14:0]) : (&tmr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tmr_q       <= '0;
            en_steer_q  <= 1'b0;
            rider_off_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tmr_q <= '0;
                    if (sum_gt_min) begin
                        state_q     <= WAIT;
                        rider_off_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (sum_lt_min) begin
                        state_q     <= IDLE;
                        tmr_q       <= '0;
                        rider_off_q <= 1'b1;
                    end else if (diff_gt_1_4) begin
                        tmr_q <= '0;
                    end else if (tmr_full) begin
                        // Leaving on the full count means the timer never wraps.
                        state_q    <= STEER_EN;
                        tmr_q      <= '0;
                        en_steer_q <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q + 26'd1;
                    end
                end
                STEER_EN: begin
                    tmr_q <= '0;
                    if (sum_lt_min) begin
                        state_q     <= IDLE;
                        en_steer_q  <= 1'b0;
                        rider_off_q <= 1'b1;
                    end else if (diff_gt_15_16) begin
                        state_q    <= WAIT;
                        en_steer_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    tmr_q       <= '0;
                    en_steer_q  <= 1'b0;
                    rider_off_q <= 1'b1;
                end
            endcase
        end
    end

    assign en_steer  = en_steer_q;
    assign rider_off = rider_off_q;

endmodule

// File: tb/tb_steer_en.sv
// Directed bench for steer_en (FAST_SIM=1): stimulus queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_steer_en;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        en_steer;
    logic        rider_off;

    steer_en #(
        .FAST_SIM      (1),
        .MIN_RIDER_WT  (12'h200),
        .WT_HYSTERESIS (12'h040)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .en_steer  (en_steer),
        .rider_off (rider_off)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic        en;
        logic        off;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc   = 0;
    int          total = 0;
    int          bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every queued expectation is due at the negedge after its edge.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            total++;
            if (e.cyc != cyc || en_steer !== e.en || rider_off !== e.off) begin
                bad++;
                $display("FAIL %s cyc=%0d (due %0d): en_steer=%b rider_off=%b, expected en_steer=%b rider_off=%b",
                         e.name, cyc, e.cyc, en_steer, rider_off, e.en, e.off);
            end
        end
    end

    task automatic push(input logic en, input logic off, input string nm);
        exp_t e;
        e.cyc  = cyc + 1;
        e.en   = en;
        e.off  = off;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Apply one input vector for n edges; outputs after edges 1..n-1 must be
    // (en,off), after edge n (len,loff). Long holds are checked sparsely.
    task automatic hold(input logic [11:0] l, input logic [11:0] r, input logic rs,
                        input int n, input logic en, input logic off,
                        input logic len, input logic loff, input string nm);
        for (int i = 1; i <= n; i++) begin
            lft_ld  = l;
            rght_ld = r;
            rst     = rs;
            if (i == n)
                push(len, loff, nm);
            else if (i <= 2 || i >= n - 2 || (i % 1024) == 0)
                push(en, off, nm);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst     = 1'b1;
        lft_ld  = 12'h300;
        rght_ld = 12'h300;

        hold(12'h300, 12'h300, 1'b1, 2,     1'b0, 1'b1, 1'b0, 1'b1, "reset");
        hold(12'h000, 12'h000, 1'b0, 2,     1'b0, 1'b1, 1'b0, 1'b1, "idle_empty");
        hold(12'h100, 12'h100, 1'b0, 2,     1'b0, 1'b1, 1'b0, 1'b1, "idle_inband");
        hold(12'h120, 12'h120, 1'b0, 2,     1'b0, 1'b1, 1'b0, 1'b1, "idle_eq_hi");
        // Edge 1 enters WAIT, edges 2..32768 count 1..32767, edge 32769 steers.
        hold(12'h180, 12'h180, 1'b0, 32769, 1'b0, 1'b0, 1'b1, 1'b0, "bal_mount");
        hold(12'h0E0, 12'h0E0, 1'b0, 2,     1'b1, 1'b0, 1'b1, 1'b0, "steer_eq_lo");
        hold(12'h300, 12'h080, 1'b0, 2,     1'b1, 1'b0, 1'b1, 1'b0, "steer_quarter");
        hold(12'h3E0, 12'h020, 1'b0, 2,     1'b1, 1'b0, 1'b1, 1'b0, "steer_eq_15_16");
        hold(12'h3F0, 12'h010, 1'b0, 1,     1'b0, 1'b0, 1'b0, 1'b0, "one_foot_lift");
        hold(12'h180, 12'h180, 1'b0, 1000,  1'b0, 1'b0, 1'b0, 1'b0, "wait_count");
        hold(12'h100, 12'h100, 1'b0, 1000,  1'b0, 1'b0, 1'b0, 1'b0, "wait_inband");
        hold(12'h180, 12'h180, 1'b1, 1,     1'b0, 1'b1, 1'b0, 1'b1, "rst_mid_wait");
        hold(12'h300, 12'h080, 1'b0, 500,   1'b0, 1'b0, 1'b0, 1'b0, "unbal_mount");
        // Timer restarts from 0 on the first balanced edge: steer on edge 32768.
        hold(12'h1C0, 12'h1C0, 1'b0, 32768, 1'b0, 1'b0, 1'b1, 1'b0, "bal_after_unbal");
        hold(12'h0D0, 12'h0D0, 1'b0, 1,     1'b0, 1'b1, 1'b0, 1'b1, "step_off");
        hold(12'h180, 12'h180, 1'b0, 1,     1'b0, 1'b0, 1'b0, 1'b0, "remount");
        hold(12'h1A0, 12'h000, 1'b0, 1,     1'b0, 1'b1, 1'b0, 1'b1, "lt_prio_wait");

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
